// File: rtl/trig_dec_pkg.sv
// Shared definitions for the serial trigger stream decoder: FSM encoding and frame geometry.
package trig_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAGB = 2'd1,
    PRTY = 2'd2
  } state_e;

  // Clocks from start-bit sample to the next possible start bit.
  function automatic int unsigned FRAME_LEN(input int unsigned tag_w);
    return tag_w + 2;
  endfunction

endpackage

// File: rtl/trig_tag_fifo.sv
// Synchronous show-ahead FIFO holding {tag, parity-error} entries for the readout logic.
module trig_tag_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the head slot in the same edge, so a full FIFO still accepts a push then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/trigger_stream_decoder.sv
// Decodes start/tag/parity frames from the synchronised trigger pin, pulses Tack per accepted
// frame, queues {tag, parity error} for readout and keeps saturating status counters.
module trigger_stream_decoder
  import trig_dec_pkg::*;
#(
  parameter int TAG_W       = 2,
  parameter int PARITY_ODD  = 1,
  parameter int DROP_ON_ERR = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Trig,
  output logic             Tack,
  input  logic             TagRd,
  output logic             TagValid,
  output logic [TAG_W-1:0] Tag,
  output logic             TagPErr,
  output logic [CNT_W-1:0] NTrig,
  output logic [CNT_W-1:0] NPrtyErr,
  output logic [CNT_W-1:0] NSeqErr,
  output logic [CNT_W-1:0] NOvfl,
  output state_e           State
);

  localparam int BCW = $clog2(FRAME_LEN(TAG_W));

  state_e           state;
  logic [BCW-1:0]   bit_cnt;
  logic [TAG_W-1:0] tag_sr;
  logic [TAG_W-1:0] last_tag;
  logic [TAG_W-1:0] next_tag;
  logic             armed;

  logic             frame_end;
  logic             perr;
  logic             accept;
  logic             seq_bad;
  logic             ovfl;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W:0]   fifo_dout;

  assign State     = state;
  assign frame_end = (state == PRTY);
  assign perr      = ((^tag_sr) ^ Trig) != (PARITY_ODD != 0);
  assign accept    = frame_end && !(perr && (DROP_ON_ERR != 0));
  assign next_tag  = last_tag + TAG_W'(1);
  // Only clean frames take part in the sequence check; the first one after reset just arms it.
  assign seq_bad   = frame_end && !perr && armed && (tag_sr != next_tag);
  assign ovfl      = accept && fifo_full && !TagRd;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tag_sr   <= '0;
      last_tag <= '0;
      armed    <= 1'b0;
      Tack     <= 1'b0;
    end else begin
      Tack <= accept;
      case (state)
        IDLE: begin
          if (Trig) begin
            state   <= TAGB;
            bit_cnt <= '0;
          end
        end
        TAGB: begin
          tag_sr <= TAG_W'({tag_sr, Trig});
          if (bit_cnt == BCW'(TAG_W - 1)) begin
            state <= PRTY;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        PRTY: begin
          state <= IDLE;
          if (!perr) begin
            last_tag <= tag_sr;
            armed    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      NTrig    <= '0;
      NPrtyErr <= '0;
      NSeqErr  <= '0;
      NOvfl    <= '0;
    end else begin
      if (frame_end && (NTrig != '1)) begin
        NTrig <= NTrig + CNT_W'(1);
      end
      if (frame_end && perr && (NPrtyErr != '1)) begin
        NPrtyErr <= NPrtyErr + CNT_W'(1);
      end
      if (seq_bad && (NSeqErr != '1)) begin
        NSeqErr <= NSeqErr + CNT_W'(1);
      end
      if (ovfl && (NOvfl != '1)) begin
        NOvfl <= NOvfl + CNT_W'(1);
      end
    end
  end

  // Readout handshake: an entry transfers on a clock edge where TagValid and TagRd are both high;
  // TagRd while TagValid is low is ignored, and Tag/TagPErr hold until the transfer.
  trig_tag_fifo #(
    .W     (TAG_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (accept),
    .pop   (TagRd),
    .din   ({tag_sr, perr}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign TagValid = !fifo_empty;
  assign Tag      = fifo_dout[TAG_W:1];
  assign TagPErr  = fifo_dout[0];

endmodule

// File: tb/tb_trigger_stream_decoder.sv
// Directed bench for trigger_stream_decoder: default, drop-on-error and 4-bit-counter instances.
module tb_trigger_stream_decoder;
  import trig_dec_pkg::*;

  localparam int TAG_W = 2;
  localparam int DEPTH = 4;

  // Clock/reset and stimulus signals
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic trig_a = 1'b0;
  logic trig_c = 1'b0;
  logic TagRd = 1'b0;
  logic rd_off = 1'b0;

  always #5 Clock = ~Clock;

  // Main instance outputs
  logic             Tack, TagValid, TagPErr;
  logic [TAG_W-1:0] Tag;
  logic [15:0]      NTrig, NPrtyErr, NSeqErr, NOvfl;
  state_e           State;

  // Drop-on-error instance outputs
  logic             tack_d, valid_d, perr_d;
  logic [TAG_W-1:0] tag_d;
  logic [15:0]      ntrig_d, nprty_d, nseq_d, novfl_d;
  state_e           state_d;

  // CNT_W=4 instance outputs
  logic             tack_c, valid_c, perr_c;
  logic [TAG_W-1:0] tag_c;
  logic [3:0]       ntrig_c, nprty_c, nseq_c, novfl_c;
  state_e           state_c;

  trigger_stream_decoder dut (
    .Clock(Clock), .Reset(Reset), .Trig(trig_a), .Tack(Tack), .TagRd(TagRd),
    .TagValid(TagValid), .Tag(Tag), .TagPErr(TagPErr), .NTrig(NTrig),
    .NPrtyErr(NPrtyErr), .NSeqErr(NSeqErr), .NOvfl(NOvfl), .State(State)
  );

  trigger_stream_decoder #(.DROP_ON_ERR(1)) dut_drop (
    .Clock(Clock), .Reset(Reset), .Trig(trig_a), .Tack(tack_d), .TagRd(rd_off),
    .TagValid(valid_d), .Tag(tag_d), .TagPErr(perr_d), .NTrig(ntrig_d),
    .NPrtyErr(nprty_d), .NSeqErr(nseq_d), .NOvfl(novfl_d), .State(state_d)
  );

  trigger_stream_decoder #(.CNT_W(4)) dut_c4 (
    .Clock(Clock), .Reset(Reset), .Trig(trig_c), .Tack(tack_c), .TagRd(rd_off),
    .TagValid(valid_c), .Tag(tag_c), .TagPErr(perr_c), .NTrig(ntrig_c),
    .NPrtyErr(nprty_c), .NSeqErr(nseq_c), .NOvfl(novfl_c), .State(state_c)
  );

  // Scoreboard and reference model state
  int checks = 0;
  int errors = 0;
  logic [TAG_W:0] exp_q[$];
  int m_ntrig, m_nprty, m_nseq, m_novfl, m_count;
  bit m_armed;
  logic [TAG_W-1:0] m_last;
  int tack_cnt = 0;
  int tack_d_cnt = 0;
  int t0;

  always @(negedge Clock) begin
    if (Tack === 1'b1) tack_cnt++;
    if (tack_d === 1'b1) tack_d_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ntrig = 0; m_nprty = 0; m_nseq = 0; m_novfl = 0; m_count = 0;
    m_armed = 1'b0; m_last = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; trig_a = 1'b0; trig_c = 1'b0; TagRd = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    model_clear();
  endtask

  // Parity bit such that XOR(tag, parity) = 1 for a clean frame; bad inverts it.
  function automatic logic par_bit(input logic [TAG_W-1:0] t, input bit bad);
    return (^t) ^ 1'b1 ^ bad;
  endfunction

  task automatic head_check();
    logic [TAG_W:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL sb_underflow observed=0 expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk("head_valid", TagValid, 1);
      chk("head_entry", {Tag, TagPErr}, e);
    end
  endtask

  task automatic pop_one();
    head_check();
    TagRd = 1'b1;
    @(posedge Clock); #1;
    TagRd = 1'b0;
    m_count--;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
    chk("drained_valid", TagValid, 0);
  endtask

  // One frame on the main stream; optionally pops the head on the parity (push) edge.
  task automatic send_frame(input logic [TAG_W-1:0] t, input bit bad, input bit pop);
    logic [TAG_W+1:0] bits;
    logic [TAG_W-1:0] nxt;
    bits = {1'b1, t, par_bit(t, bad)};
    for (int k = TAG_W + 1; k >= 0; k--) begin
      trig_a = bits[k];
      if (k == 0 && pop) begin
        head_check();
        TagRd = 1'b1;
      end
      @(posedge Clock); #1;
    end
    trig_a = 1'b0;
    TagRd = 1'b0;
    if (pop) m_count--;
    m_ntrig++;
    if (bad) m_nprty++;
    if (!bad) begin
      nxt = m_last + 1'b1;
      if (m_armed && t != nxt) m_nseq++;
      m_last = t;
      m_armed = 1'b1;
    end
    if (m_count == DEPTH) m_novfl++;
    else begin
      exp_q.push_back({t, bad});
      m_count++;
    end
    chk("tack", Tack, 1);
    chk("ntrig", NTrig, m_ntrig);
    chk("nprty", NPrtyErr, m_nprty);
    chk("nseq", NSeqErr, m_nseq);
    chk("novfl", NOvfl, m_novfl);
    chk("tagvalid", TagValid, (m_count > 0));
  endtask

  task automatic send_c4(input logic [TAG_W-1:0] t, input bit bad);
    logic [TAG_W+1:0] bits;
    bits = {1'b1, t, par_bit(t, bad)};
    for (int k = TAG_W + 1; k >= 0; k--) begin
      trig_c = bits[k];
      @(posedge Clock); #1;
    end
    trig_c = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_state", State, IDLE);
    chk("rst_tack", Tack, 0);
    chk("rst_valid", TagValid, 0);
    chk("rst_tag", Tag, 0);
    chk("rst_perr", TagPErr, 0);
    chk("rst_ntrig", NTrig, 0);
    chk("rst_nprty", NPrtyErr, 0);
    chk("rst_nseq", NSeqErr, 0);
    chk("rst_novfl", NOvfl, 0);

    // Single clean frame, tag 2'b10
    send_frame(2'b10, 1'b0, 1'b0);
    chk("t1_tag", Tag, 2'b10);
    chk("t1_perr", TagPErr, 0);
    pop_one();

    // Parity-error frame: kept by default instance, dropped by drop instance
    do_reset();
    t0 = tack_d_cnt;
    send_frame(2'b10, 1'b1, 1'b0);
    chk("t2_drop_tack", tack_d, 0);
    chk("t2_drop_valid", valid_d, 0);
    chk("t2_drop_nprty", nprty_d, 1);
    chk("t2_drop_ntrig", ntrig_d, 1);
    chk("t2_perr_flag", TagPErr, 1);
    pop_one();
    chk("t2_drop_tacks", tack_d_cnt - t0, 0);

    // Back-to-back tags 0,1,3,0
    do_reset();
    t0 = tack_cnt;
    send_frame(2'd0, 1'b0, 1'b0);
    send_frame(2'd1, 1'b0, 1'b0);
    send_frame(2'd3, 1'b0, 1'b0);
    send_frame(2'd0, 1'b0, 1'b0);
    @(negedge Clock); #1;
    chk("t3_nseq", NSeqErr, 1);
    chk("t3_tacks", tack_cnt - t0, 4);
    drain();

    // FIFO overflow, then push with simultaneous pop while full
    do_reset();
    t0 = tack_cnt;
    for (int i = 0; i < 6; i++) send_frame(2'(i), 1'b0, 1'b0);
    @(negedge Clock); #1;
    chk("t4_novfl", NOvfl, 2);
    chk("t4_tacks", tack_cnt - t0, 6);
    send_frame(2'd2, 1'b0, 1'b1);
    chk("t4_novfl_pop", NOvfl, 2);
    drain();

    // Reset during tag cycle 2 aborts the frame and disarms the sequence check
    t0 = tack_cnt;
    trig_a = 1'b1; @(posedge Clock); #1;
    trig_a = 1'b1; @(posedge Clock); #1;
    Reset = 1'b1; trig_a = 1'b0; @(posedge Clock); #1;
    Reset = 1'b0;
    model_clear();
    chk("t5_state", State, IDLE);
    repeat (3) @(posedge Clock); #1;
    chk("t5_tacks", tack_cnt - t0, 0);
    chk("t5_ntrig", NTrig, 0);
    chk("t5_valid", TagValid, 0);
    send_frame(2'd1, 1'b0, 1'b0);
    chk("t5_nseq", NSeqErr, 0);
    drain();

    // Counter saturation with 4-bit counters
    for (int i = 0; i < 17; i++) send_c4(2'($urandom_range(0, 3)), 1'b1);
    chk("t6_nprty", nprty_c, 15);
    chk("t6_ntrig", ntrig_c, 15);
    chk("t6_nseq", nseq_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
